// File: rtl/tweezer_param_loader.sv
// Host command frame parser that loads PI controller parameters (kp, ki, setpoint, mode bits).
// Optional fifth checksum byte is compiled in with `define TWEEZER_CMD_CHECKSUM_EN.
module tweezer_param_loader #(
    parameter int COEFF_W        = 10,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [COEFF_W-1:0] PI_kp,
    output logic [COEFF_W-1:0] PI_ki,
    output logic               PI_kp_update,
    output logic               PI_ki_update,
    output logic [DATA_W-1:0]  PI_setpoint,
    output logic               PI_enable,
    output logic               PI_freeze,
    output logic               addFeedback,
    output logic               PI_reset,
    input  logic               err_clear,
    output logic               frame_error,
    output logic [7:0]         frame_count
);

    localparam logic [7:0]        SYNC      = 8'hA5;
    localparam int                TCNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       COEFF_MAX = 32'((64'd1 << COEFF_W) - 64'd1);

`ifdef TWEEZER_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CSUM, COMMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, COMMIT} state_t;
`endif

    state_t             state, state_nxt;
    logic               accept, in_frame, commit_go, timeout;
    logic [TCNT_W-1:0]  tcnt;
    logic [7:0]         addr_q, dhi_q;
    logic [15:0]        frame_data;
    logic               csum_ok, addr_ok, frame_ok, err_event, coeff_sat;
    logic [COEFF_W-1:0] coeff_val;

    assign accept = rx_valid && rx_ready;

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave one
        // unassigned and infer a latch.
        state_nxt = state;
        commit_go = 1'b0;
        in_frame  = 1'b0;
        case (state)
            IDLE: if (accept && rx_data == SYNC) state_nxt = ADDR;
            ADDR: begin
                in_frame = 1'b1;
                if (accept) state_nxt = DHI;
            end
            DHI: begin
                in_frame = 1'b1;
                if (accept) state_nxt = DLO;
            end
            DLO: begin
                in_frame = 1'b1;
                if (accept) begin
`ifdef TWEEZER_CMD_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = COMMIT;
                    commit_go = 1'b1;
`endif
                end
            end
`ifdef TWEEZER_CMD_CHECKSUM_EN
            CSUM: begin
                in_frame = 1'b1;
                if (accept) begin
                    state_nxt = COMMIT;
                    commit_go = 1'b1;
                end
            end
`endif
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        timeout = in_frame && !accept && (tcnt == TCNT_LAST);
        if (timeout) state_nxt = IDLE;
    end

    // The last byte is still on rx_data at the commit edge, so it feeds the decode directly.
`ifdef TWEEZER_CMD_CHECKSUM_EN
    logic [7:0] dlo_q;
    assign frame_data = {dhi_q, dlo_q};
    assign csum_ok    = (rx_data == (addr_q ^ dhi_q ^ dlo_q));
`else
    assign frame_data = {dhi_q, rx_data};
    assign csum_ok    = 1'b1;
`endif

    assign addr_ok   = addr_q inside {[8'h01:8'h05]};
    assign frame_ok  = addr_ok && csum_ok;
    assign err_event = timeout || (commit_go && !frame_ok);
    assign coeff_sat = 32'(frame_data) > COEFF_MAX;
    assign coeff_val = coeff_sat ? '1 : COEFF_W'(frame_data);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_ready <= (state_nxt != COMMIT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (in_frame && !accept && !timeout) begin
            tcnt <= tcnt + TCNT_W'(1);
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            dhi_q  <= '0;
`ifdef TWEEZER_CMD_CHECKSUM_EN
            dlo_q  <= '0;
`endif
        end else if (accept) begin
            case (state)
                ADDR:    addr_q <= rx_data;
                DHI:     dhi_q  <= rx_data;
`ifdef TWEEZER_CMD_CHECKSUM_EN
                DLO:     dlo_q  <= rx_data;
`endif
                default: ;
            endcase
        end
    end

    // Register update and strobe land together on the edge that enters COMMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PI_kp        <= '0;
            PI_ki        <= '0;
            PI_kp_update <= 1'b0;
            PI_ki_update <= 1'b0;
            PI_setpoint  <= '0;
            PI_enable    <= 1'b0;
            PI_freeze    <= 1'b0;
            addFeedback  <= 1'b0;
            PI_reset     <= 1'b0;
            frame_error  <= 1'b0;
            frame_count  <= '0;
        end else begin
            PI_kp_update <= 1'b0;
            PI_ki_update <= 1'b0;
            PI_reset     <= 1'b0;
            if (commit_go && frame_ok) begin
                frame_count <= frame_count + 8'd1;
                case (addr_q)
                    8'h01: begin
                        PI_kp        <= coeff_val;
                        PI_kp_update <= 1'b1;
                    end
                    8'h02: begin
                        PI_ki        <= coeff_val;
                        PI_ki_update <= 1'b1;
                    end
                    8'h03: PI_setpoint <= DATA_W'(frame_data);
                    8'h04: begin
                        PI_enable   <= frame_data[0];
                        PI_freeze   <= frame_data[1];
                        addFeedback <= frame_data[2];
                    end
                    8'h05:   PI_reset <= 1'b1;
                    default: ;
                endcase
            end
            if (err_event) begin
                frame_error <= 1'b1;
            end else if (err_clear) begin
                frame_error <= 1'b0;
            end
        end
    end

endmodule
